// File: rtl/display_scroll_controller_pkg.sv
// Shared constants and types for the seven-segment scroll controller.
package display_pkg;

  localparam int MSG_LEN = 16;
  localparam int PTR_W   = 4;
  localparam int NIB_W   = 4;

  // Controller operating mode; the encoding doubles as the FSM state value.
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Power-on message: nibble i holds value i, so the display starts at 0123.
  localparam logic [MSG_LEN*NIB_W-1:0] RESET_MSG = 64'hFEDC_BA98_7654_3210;

  // Nibble idx of the power-on message.
  function automatic logic [NIB_W-1:0] reset_nibble(input int idx);
    return RESET_MSG[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/display_scroll_controller_rise_detect.sv
// Rising-edge detector for an already-debounced button level.
// The history flop resets to 1 so a button held through reset release
// is not mistaken for a fresh press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/display_scroll_controller.sv
// Scroll controller: holds a 16-nibble message and presents a 4-nibble
// window of it to the LED driver. The window start (ptr) advances on a
// step-button press, or on a prescaled tick while in auto mode.
//
// Interface semantics: there is no valid/ready handshake here. load_en is
// a fire-and-forget write strobe, taken on every rising edge where it is
// high, with no back-pressure; advance is a one-cycle notification pulse
// that the consumer cannot stall.
//
// The FSM state is observable on auto_mode (1 = AUTO).
module display_scroll_controller
  import display_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic             btn_mode,
  input  logic             load_en,
  input  logic [PTR_W-1:0] load_addr,
  input  logic [NIB_W-1:0] load_data,
  output logic [15:0]      digits,
  output logic [PTR_W-1:0] ptr,
  output logic             auto_mode,
  output logic             advance
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam logic [0:0] ST_MANUAL = MODE_MANUAL;
  localparam logic [0:0] ST_AUTO   = MODE_AUTO;

  logic             step_rise;
  logic             mode_rise;
  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [PTR_W-1:0] ptr_nxt;
  logic             adv_now;
  logic             terminal;
  logic [NIB_W-1:0] msg [MSG_LEN];
  logic [PTR_W-1:0] p1, p2, p3;

  rise_detect u_step_rise (
    .clk   (clk),
    .reset (reset),
    .level (btn_step),
    .rise  (step_rise)
  );

  rise_detect u_mode_rise (
    .clk   (clk),
    .reset (reset),
    .level (btn_mode),
    .rise  (mode_rise)
  );

  // Next-state logic: a step press and a terminal tick on the same edge
  // merge into a single advance; a mode press toggles state independently.
  always_comb begin
    terminal     = (state == ST_AUTO) && (tick_cnt == CNT_LAST);
    adv_now      = step_rise | terminal;
    state_nxt    = mode_rise ? ~state : state;
    ptr_nxt      = adv_now ? ptr + PTR_W'(1) : ptr;
    tick_cnt_nxt = tick_cnt;
    if (mode_rise)               tick_cnt_nxt = '0;
    else if (state == ST_MANUAL) tick_cnt_nxt = '0;
    else if (adv_now)            tick_cnt_nxt = '0;
    else                         tick_cnt_nxt = tick_cnt + CNT_W'(1);
  end

  // FSM, tick prescaler, window pointer and advance pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_MANUAL;
      tick_cnt <= '0;
      ptr      <= '0;
      advance  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      ptr      <= ptr_nxt;
      advance  <= adv_now;
    end
  end

  assign auto_mode = (state == ST_AUTO);

  // Message register file; writes are accepted in either mode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) msg[i] <= reset_nibble(i);
    end else if (load_en) begin
      msg[load_addr] <= load_data;
    end
  end

  // Window indices wrap naturally in 4-bit arithmetic.
  always_comb begin
    p1 = ptr + PTR_W'(1);
    p2 = ptr + PTR_W'(2);
    p3 = ptr + PTR_W'(3);
  end

  // Registered display word, leftmost digit first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) digits <= 16'h0123;
    else       digits <= {msg[ptr], msg[p1], msg[p2], msg[p3]};
  end

endmodule

// File: tb/tb_display_scroll_controller.sv
// Self-checking bench for display_scroll_controller with TICK_DIV = 4.
module tb_display_scroll_controller;

  localparam int TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_step, btn_mode, load_en;
  logic [3:0]  load_addr, load_data;
  logic [15:0] digits;
  logic [3:0]  ptr;
  logic        auto_mode, advance;

  int total = 0;
  int bad   = 0;
  int adv_seen = 0;

  // Reference model state
  logic [3:0]  m_msg [16];
  int          m_ptr;
  logic        m_auto, m_adv;
  logic        prev_step, prev_mode;
  int          cyc, anchor;
  logic [15:0] exp_q [$];

  display_scroll_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_step  (btn_step),
    .btn_mode  (btn_mode),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .digits    (digits),
    .ptr       (ptr),
    .auto_mode (auto_mode),
    .advance   (advance)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] window();
    return {m_msg[m_ptr], m_msg[(m_ptr + 1) % 16], m_msg[(m_ptr + 2) % 16], m_msg[(m_ptr + 3) % 16]};
  endfunction

  // True when the upcoming edge is an auto-mode tick edge.
  function automatic bit terminal_next();
    return m_auto && (cyc != anchor) && (((cyc - anchor) % TICK_DIV) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = 4'(i);
    m_ptr = 0; m_auto = 1'b0; m_adv = 1'b0;
    prev_step = 1'b1; prev_mode = 1'b1;
    cyc = 0; anchor = 0;
    exp_q.delete();
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge();
    bit step_r, mode_r, term;
    step_r = btn_step && !prev_step;
    mode_r = btn_mode && !prev_mode;
    term   = terminal_next();
    exp_q.push_back(window());
    m_adv = step_r || term;
    if (m_adv) m_ptr = (m_ptr + 1) % 16;
    if (mode_r) begin
      m_auto = !m_auto;
      anchor = cyc;
    end else if (step_r && m_auto) begin
      anchor = cyc;
    end
    if (load_en) m_msg[load_addr] = load_data;
    prev_step = btn_step;
    prev_mode = btn_mode;
    cyc++;
  endtask

  task automatic check_outputs();
    logic [15:0] exp_d;
    exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0123;
    chk("digits", digits, exp_d);
    chk("ptr", 16'(ptr), 16'(m_ptr));
    chk("auto_mode", 16'(auto_mode), 16'(m_auto));
    chk("advance", 16'(advance), 16'(m_adv));
    if (advance === 1'b1) adv_seen++;
  endtask

  // Driver: advance n cycles, updating the model and checking at negedge.
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
    end
  endtask

  // Asynchronous reset mid-cycle; called at a negedge.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async_rst_digits", digits, 16'h0123);
    chk("async_rst_ptr", 16'(ptr), 16'h0000);
    chk("async_rst_auto", 16'(auto_mode), 16'h0000);
    chk("async_rst_adv", 16'(advance), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
  endtask

  initial begin
    reset = 1'b1;
    btn_step = 1'b0; btn_mode = 1'b0; load_en = 1'b0;
    load_addr = 4'h0; load_data = 4'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state and idle
    check_outputs();
    adv_seen = 0;
    run(20);
    chk("idle_digits", digits, 16'h0123);
    chk("idle_ptr", 16'(ptr), 16'h0000);
    chk("idle_no_adv", 16'(adv_seen), 16'h0000);

    // Manual stepping
    for (int i = 0; i < 3; i++) begin
      btn_step = 1'b1; run(5);
      btn_step = 1'b0; run(5);
    end
    chk("man3_ptr", 16'(ptr), 16'h0003);
    chk("man3_digits", digits, 16'h3456);
    for (int i = 0; i < 16; i++) begin
      btn_step = 1'b1; run(5);
      btn_step = 1'b0; run(5);
      if (i == 10) begin
        chk("man14_ptr", 16'(ptr), 16'h000E);
        chk("man14_digits", digits, 16'hEF01);
      end
    end
    chk("wrap_ptr", 16'(ptr), 16'h0003);

    // Auto mode: five ticks, then exit and freeze
    adv_seen = 0;
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0; run(3);
    chk("auto_no_early", 16'(adv_seen), 16'h0000);
    run(17);
    chk("auto_pulses", 16'(adv_seen), 16'h0005);
    chk("auto_ptr", 16'(ptr), 16'h0008);
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0;
    adv_seen = 0;
    run(15);
    chk("frozen_pulses", 16'(adv_seen), 16'h0000);
    chk("frozen_ptr", 16'(ptr), 16'h0008);
    chk("frozen_manual", 16'(auto_mode), 16'h0000);

    // Collision: step rise on the terminal tick edge
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0; run(3);
    btn_step = 1'b1; run(1);
    chk("coll_adv", 16'(advance), 16'h0001);
    chk("coll_ptr", 16'(ptr), 16'h0009);
    btn_step = 1'b0;
    adv_seen = 0;
    run(3);
    chk("coll_gap", 16'(adv_seen), 16'h0000);
    run(1);
    chk("coll_next_tick", 16'(advance), 16'h0001);
    chk("coll_next_ptr", 16'(ptr), 16'h000A);
    // Mode and step rise together
    btn_mode = 1'b1; btn_step = 1'b1; run(1);
    chk("ms_auto", 16'(auto_mode), 16'h0000);
    chk("ms_ptr", 16'(ptr), 16'h000B);
    btn_mode = 1'b0; btn_step = 1'b0; run(5);

    // Loads
    apply_reset();
    run(2);
    load(4'h2, 4'hA); run(1);
    load_en = 1'b0; run(1);
    chk("load_vis", digits, 16'h01A3);
    load(4'h9, 4'h5); run(1);
    load_en = 1'b0; run(1);
    chk("load_hidden", digits, 16'h01A3);
    apply_reset();
    run(2);
    btn_step = 1'b1; load(4'h2, 4'hA); run(1);
    btn_step = 1'b0; load_en = 1'b0; run(1);
    chk("load_step_digits", digits, 16'h1A34);
    chk("load_step_ptr", 16'(ptr), 16'h0001);

    // Button held through reset release
    btn_step = 1'b1;
    apply_reset();
    adv_seen = 0;
    run(10);
    chk("held_no_adv", 16'(adv_seen), 16'h0000);
    chk("held_ptr", 16'(ptr), 16'h0000);
    btn_step = 1'b0; run(2);

    // Reset in the middle of auto mode with a modified message
    load(4'h0, 4'hF); run(1);
    load_en = 1'b0;
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0; run(6);
    apply_reset();
    run(1);
    chk("mid_rst_digits", digits, 16'h0123);
    adv_seen = 0;
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0; run(3);
    chk("re_auto_no_early", 16'(adv_seen), 16'h0000);
    run(1);
    chk("re_auto_first", 16'(advance), 16'h0001);
    btn_mode = 1'b1; run(1);
    btn_mode = 1'b0; run(2);

    // Randomized phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) btn_step = ~btn_step;
      if ($urandom_range(0, 14) == 0) begin
        if (!(btn_mode == 1'b0 && terminal_next())) btn_mode = ~btn_mode;
      end
      load_en   = ($urandom_range(0, 4) == 0);
      load_addr = 4'($urandom_range(0, 15));
      load_data = 4'($urandom_range(0, 15));
      run(1);
    end
    load_en = 1'b0;
    run(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
